// File: rtl/keypad_scan_db_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan_db_if
//  Description : Event bus between the keypad scanner and its consumer.
//                Carries the latched key event, its valid/ready handshake
//                and the debounced status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scan_db_if #(
    parameter int N  = 12,
    parameter int KW = 4
);
    logic [N-1:0]  out;
    logic [KW-1:0] key_idx;
    logic          valid;
    logic          ready;
    logic          held;
    logic          multi;
    logic          overrun;

    modport master (
        output out,
        output key_idx,
        output valid,
        output held,
        output multi,
        output overrun,
        input  ready
    );

    modport slave (
        input  out,
        input  key_idx,
        input  valid,
        input  held,
        input  multi,
        input  overrun,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scan_db.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan_db
//  Description : Row-at-a-time keypad matrix scanner with frame debouncing.
//                Emits one event per debounced key-down over a valid/ready
//                handshake, and reports chords and dropped events.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_db #(
    parameter int ROWS     = 4,
    parameter int COLS     = 3,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] in_from_keypad,
    output logic [ROWS-1:0] out_to_keypad,
    keypad_scan_db_if.master ev
);

    localparam int N  = ROWS * COLS;
    localparam int KW = $clog2(N);
    localparam int TW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(DEBOUNCE + 1);

    localparam logic [TW-1:0] c_TIMER_MAX = TW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] c_ROW_MAX   = RW'(ROWS - 1);
    localparam logic [CW-1:0] c_DB        = CW'(DEBOUNCE);

    // Frame classification; also the encoding of the debounced state
    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_KEY   = 2'd1,
        CLS_MULTI = 2'd2
    } cls_t;

    logic [COLS-1:0] r_sync1;
    logic [COLS-1:0] r_sync2;
    logic [TW-1:0]   r_timer;
    logic [RW-1:0]   r_row;
    logic [N-1:0]    r_snap;
    cls_t            r_prev_cls;
    logic [KW-1:0]   r_prev_idx;
    logic [CW-1:0]   r_cnt;
    cls_t            r_deb_cls;
    logic [KW-1:0]   r_deb_idx;
    logic            r_valid;
    logic            r_overrun;
    logic [N-1:0]    r_out;
    logic [KW-1:0]   r_key_idx;

    logic            w_tick;
    logic            w_frame_end;
    logic [N-1:0]    w_frame;
    cls_t            w_cls;
    logic [KW-1:0]   w_idx;
    logic            w_same;
    logic [CW-1:0]   w_cnt_next;
    logic            w_differs_deb;
    logic            w_accept;
    logic            w_event;
    cls_t            w_deb_cls_nxt;
    logic [KW-1:0]   w_deb_idx_nxt;

    assign w_tick      = (r_timer == c_TIMER_MAX);
    assign w_frame_end = w_tick && (r_row == c_ROW_MAX);

    // Two-flop synchroniser for the asynchronous column lines
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_from_keypad;
            r_sync2 <= r_sync1;
        end
    end

    // Slot timer: one tick per SCAN_DIV cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Row pointer advances after each row's sample
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_row <= '0;
        end else if (w_tick) begin
            r_row <= w_frame_end ? '0 : r_row + 1'b1;
        end
    end

    // One-hot row drive; row 0 sits on the MSB
    always_comb begin
        out_to_keypad = '0;
        for (int rr = 0; rr < ROWS; rr++) begin
            out_to_keypad[ROWS-1-rr] = (r_row == RW'(rr));
        end
    end

    // Snapshot with the current row's columns merged in, so the frame-end
    // tick classifies the complete frame including its last row
    always_comb begin
        w_frame = r_snap;
        for (int rr = 0; rr < ROWS; rr++) begin
            if (r_row == RW'(rr)) begin
                for (int cc = 0; cc < COLS; cc++) begin
                    w_frame[rr*COLS+cc] = r_sync2[COLS-1-cc];
                end
            end
        end
    end

    // Capture the sampled row on every tick
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_snap <= '0;
        end else if (w_tick) begin
            r_snap <= w_frame;
        end
    end

    // Classify the frame as none / single key (with index) / chord
    always_comb begin
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_frame[i]) begin
                w_idx = KW'(i);
            end
        end
        if (w_frame == '0) begin
            w_cls = CLS_NONE;
        end else if ((w_frame & (w_frame - N'(1))) == '0) begin
            w_cls = CLS_KEY;
        end else begin
            w_cls = CLS_MULTI;
        end
    end

    assign w_same        = (w_cls == r_prev_cls) &&
                           ((w_cls != CLS_KEY) || (w_idx == r_prev_idx));
    assign w_cnt_next    = w_same ? ((r_cnt == c_DB) ? r_cnt : r_cnt + 1'b1)
                                  : CW'(1);
    assign w_differs_deb = (w_cls != r_deb_cls) ||
                           ((w_cls == CLS_KEY) && (w_idx != r_deb_idx));
    assign w_accept      = w_frame_end && (w_cnt_next == c_DB) && w_differs_deb;
    assign w_event       = w_accept && (w_cls == CLS_KEY);

    // Previous-frame class and stability count, updated once per frame
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev_cls <= CLS_NONE;
            r_prev_idx <= '0;
            r_cnt      <= '0;
        end else if (w_frame_end) begin
            r_prev_cls <= w_cls;
            r_prev_idx <= w_idx;
            r_cnt      <= w_cnt_next;
        end
    end

    // Debounced state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_deb_cls <= CLS_NONE;
            r_deb_idx <= '0;
        end else begin
            r_deb_cls <= w_deb_cls_nxt;
            r_deb_idx <= w_deb_idx_nxt;
        end
    end

    // Debounced state takes the frame class once it has been stable long enough
    always_comb begin
        w_deb_cls_nxt = r_deb_cls;
        w_deb_idx_nxt = r_deb_idx;
        if (w_accept) begin
            w_deb_cls_nxt = w_cls;
            w_deb_idx_nxt = w_idx;
        end
    end

    // Event register: loads when the consumer is free, otherwise flags overrun
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_out     <= '0;
            r_key_idx <= '0;
        end else if (w_event) begin
            if (!r_valid || ev.ready) begin
                r_valid   <= 1'b1;
                r_out     <= N'(1) << w_idx;
                r_key_idx <= w_idx;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && ev.ready) begin
            r_valid <= 1'b0;
        end
    end

    assign ev.out     = r_out;
    assign ev.key_idx = r_key_idx;
    assign ev.valid   = r_valid;
    assign ev.overrun = r_overrun;
    assign ev.held    = (r_deb_cls == CLS_KEY);
    assign ev.multi   = (r_deb_cls == CLS_MULTI);

endmodule
`default_nettype wire
